// File: rtl/uart_rx_frame_counter_if.sv
// rtl/uart_rx_frame_counter_if.sv - config inputs and timing/status outputs of the UART RX frame counter
interface uart_rx_frame_counter_if #(parameter int PRESCALE_W = 6);
   logic                  enable;
   logic [PRESCALE_W-1:0] Prescale;
   logic [3:0]            DATA_LEN;
   logic                  PAR_EN;
   logic                  STOP2;
   logic [PRESCALE_W-1:0] edge_cnt;
   logic [3:0]            bit_cnt;
   logic                  sample_stb;
   logic [1:0]            sample_idx;
   logic                  bit_done;
   logic                  frame_done;
   logic                  busy;
   logic                  cfg_err;

   modport master (
      output enable, Prescale, DATA_LEN, PAR_EN, STOP2,
      input  edge_cnt, bit_cnt, sample_stb, sample_idx, bit_done, frame_done, busy, cfg_err
   );

   modport slave (
      input  enable, Prescale, DATA_LEN, PAR_EN, STOP2,
      output edge_cnt, bit_cnt, sample_stb, sample_idx, bit_done, frame_done, busy, cfg_err
   );
endinterface

// File: rtl/uart_rx_frame_counter.sv
// rtl/uart_rx_frame_counter.sv - per-bit/per-frame timing counter for a UART receiver
module uart_rx_frame_counter #(
   parameter int PRESCALE_W = 6
) (
   input  logic                       CLK,
   input  logic                       RST,
   uart_rx_frame_counter_if.slave     bus
);
   typedef enum logic {IDLE, RUN} state_t;

   state_t                state;
   logic [PRESCALE_W-1:0] p_q;
   logic [PRESCALE_W-1:0] edge_q;
   logic [3:0]            fb_q;
   logic [3:0]            bit_q;
   logic                  err_q;

   logic                  cfg_ok;
   logic [3:0]            frame_bits;
   logic [PRESCALE_W-1:0] p_m1;
   logic [PRESCALE_W-1:0] mid;
   logic [PRESCALE_W-1:0] mid_lo;
   logic [PRESCALE_W-1:0] mid_hi;
   logic                  running;
   logic                  last_edge;
   logic                  last_bit;

   assign cfg_ok     = (bus.Prescale >= PRESCALE_W'(4)) &&
                       (bus.DATA_LEN >= 4'd5) && (bus.DATA_LEN <= 4'd9);
   assign frame_bits = 4'd2 + bus.DATA_LEN + {3'b000, bus.PAR_EN} + {3'b000, bus.STOP2};

   assign p_m1      = p_q - PRESCALE_W'(1);
   assign mid       = p_q >> 1;
   assign mid_lo    = mid - PRESCALE_W'(1);
   assign mid_hi    = mid + PRESCALE_W'(1);
   assign running   = (state == RUN) && bus.enable;
   assign last_edge = (edge_q == p_m1);
   assign last_bit  = (bit_q == fb_q - 4'd1);

   // Three strobes centred on the middle of the bit for majority voting downstream.
   always_comb begin
      bus.sample_stb = 1'b0;
      bus.sample_idx = 2'd0;
      if (running) begin
         if (edge_q == mid_lo) begin
            bus.sample_stb = 1'b1;
            bus.sample_idx = 2'd0;
         end else if (edge_q == mid) begin
            bus.sample_stb = 1'b1;
            bus.sample_idx = 2'd1;
         end else if (edge_q == mid_hi) begin
            bus.sample_stb = 1'b1;
            bus.sample_idx = 2'd2;
         end
      end
   end

   assign bus.bit_done   = running && last_edge;
   assign bus.frame_done = running && last_edge && last_bit;
   assign bus.busy       = (state == RUN);
   assign bus.edge_cnt   = edge_q;
   assign bus.bit_cnt    = bit_q;
   assign bus.cfg_err    = err_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state  <= IDLE;
         p_q    <= '0;
         fb_q   <= '0;
         edge_q <= '0;
         bit_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.enable && cfg_ok) begin
                  // The latch cycle itself is edge 0 of the start bit.
                  p_q    <= bus.Prescale;
                  fb_q   <= frame_bits;
                  edge_q <= PRESCALE_W'(1);
                  bit_q  <= 4'd0;
                  err_q  <= 1'b0;
                  state  <= RUN;
               end else begin
                  err_q  <= bus.enable;
               end
            end
            RUN: begin
               err_q <= 1'b0;
               if (!bus.enable) begin
                  edge_q <= '0;
                  bit_q  <= 4'd0;
                  state  <= IDLE;
               end else if (last_edge) begin
                  edge_q <= '0;
                  if (last_bit) begin
                     bit_q <= 4'd0;
                     state <= IDLE;
                  end else begin
                     bit_q <= bit_q + 4'd1;
                  end
               end else begin
                  edge_q <= edge_q + PRESCALE_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_rx_frame_counter.sv
// tb/tb_uart_rx_frame_counter.sv - scoreboard bench for uart_rx_frame_counter against a cycle-index model
module tb_uart_rx_frame_counter;
   typedef struct packed {
      logic       busy;
      logic       err;
      logic [5:0] ecnt;
      logic [3:0] bcnt;
      logic       stb;
      logic [1:0] idx;
      logic       bd;
      logic       fd;
   } obs_t;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   uart_rx_frame_counter_if #(.PRESCALE_W(6)) bus ();
   uart_rx_frame_counter #(.PRESCALE_W(6)) dut (.CLK(CLK), .RST(RST), .bus(bus.slave));

   obs_t sbq[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   first_fd = -1;

   // Model: a frame is just a running cycle index k; edge = k mod P, bit = k div P.
   bit   m_run = 1'b0;
   int   m_k = 0, m_p = 0, m_fb = 0;
   bit   m_err = 1'b0;
   bit   cur_e = 1'b0, cur_par = 1'b0, cur_st2 = 1'b0;
   int   cur_pre = 0, cur_dl = 0;

   function automatic obs_t expected();
      obs_t x;
      int   ed, bt, m;
      x = '0;
      ed = m_run ? m_k % m_p : 0;
      bt = m_run ? m_k / m_p : 0;
      x.busy = m_run;
      x.err  = m_err;
      x.ecnt = 6'(ed);
      x.bcnt = 4'(bt);
      if (m_run && cur_e) begin
         m = m_p / 2;
         if (ed >= m - 1 && ed <= m + 1) begin
            x.stb = 1'b1;
            x.idx = 2'(ed - (m - 1));
         end
         x.bd = (ed == m_p - 1);
         x.fd = x.bd && (bt == m_fb - 1);
      end
      return x;
   endfunction

   function automatic void model_update();
      bit legal;
      legal = (cur_pre >= 4) && (cur_dl >= 5) && (cur_dl <= 9);
      if (!m_run) begin
         if (cur_e && legal) begin
            m_run = 1'b1;
            m_k   = 1;
            m_p   = cur_pre;
            m_fb  = 2 + cur_dl + int'(cur_par) + int'(cur_st2);
            m_err = 1'b0;
         end else begin
            m_err = cur_e;
         end
      end else begin
         m_err = 1'b0;
         if (!cur_e) begin
            m_run = 1'b0;
            m_k   = 0;
         end else begin
            m_k++;
            if (m_k == m_p * m_fb) begin
               m_run = 1'b0;
               m_k   = 0;
            end
         end
      end
   endfunction

   task automatic step(input bit e, input int pre, input int dl, input bit par, input bit st2);
      @(posedge CLK);
      #1;
      model_update();
      cur_e = e; cur_pre = pre; cur_dl = dl; cur_par = par; cur_st2 = st2;
      bus.enable   = e;
      bus.Prescale = 6'(pre);
      bus.DATA_LEN = 4'(dl);
      bus.PAR_EN   = par;
      bus.STOP2    = st2;
      sbq.push_back(expected());
   endtask

   task automatic run(input int n, input bit e, input int pre, input int dl, input bit par, input bit st2);
      for (int i = 0; i < n; i++) step(e, pre, dl, par, st2);
   endtask

   task automatic monitor();
      obs_t g, x;
      forever begin
         @(negedge CLK);
         cyc++;
         if (!RST && sbq.size() > 0) begin
            x = sbq.pop_front();
            g = {bus.busy, bus.cfg_err, bus.edge_cnt, bus.bit_cnt, bus.sample_stb,
                 bus.sample_idx, bus.bit_done, bus.frame_done};
            tests++;
            if (g !== x) begin
               fails++;
               $display("FAIL outputs cyc=%0d got busy=%b err=%b edge=%0d bit=%0d stb=%b idx=%0d bd=%b fd=%b required busy=%b err=%b edge=%0d bit=%0d stb=%b idx=%0d bd=%b fd=%b",
                        cyc, g.busy, g.err, g.ecnt, g.bcnt, g.stb, g.idx, g.bd, g.fd,
                        x.busy, x.err, x.ecnt, x.bcnt, x.stb, x.idx, x.bd, x.fd);
            end
            if (g.fd && first_fd < 0) first_fd = cyc;
         end
      end
   endtask

   task automatic check_zero(input string name);
      obs_t g;
      g = {bus.busy, bus.cfg_err, bus.edge_cnt, bus.bit_cnt, bus.sample_stb,
           bus.sample_idx, bus.bit_done, bus.frame_done};
      tests++;
      if (g !== '0) begin
         fails++;
         $display("FAIL %s got %h required 0", name, g);
      end
   endtask

   task automatic check_int(input string name, input int got, input int req);
      tests++;
      if (got != req) begin
         fails++;
         $display("FAIL %s got %0d required %0d", name, got, req);
      end
   endtask

   task automatic mark_start();
      @(negedge CLK);
      #1;
      cyc = 0;
      first_fd = -1;
   endtask

   initial begin
      int n, pre, dl;
      bit par, st2, e;
      fork
         monitor();
      join_none

      bus.enable = 1'b1; bus.Prescale = 6'd8; bus.DATA_LEN = 4'd8;
      bus.PAR_EN = 1'b0; bus.STOP2 = 1'b0;
      repeat (2) @(negedge CLK);
      #1 check_zero("reset_state");
      bus.enable = 1'b0;
      RST = 1'b0;

      run(3, 0, 8, 8, 0, 0);

      mark_start();
      run(170, 1, 8, 8, 0, 0);
      check_int("first_frame_done_p8_10bit", first_fd, 80);
      run(2, 0, 8, 8, 0, 0);

      mark_start();
      run(212, 1, 16, 9, 1, 1);
      check_int("first_frame_done_p16_13bit", first_fd, 208);
      run(2, 0, 16, 9, 1, 1);

      run(32, 1, 8, 8, 0, 0);
      run(48 + 170, 1, 16, 8, 0, 0);
      run(2, 0, 8, 8, 0, 0);

      run(30, 1, 8, 8, 0, 0);
      run(3, 0, 8, 8, 0, 0);

      run(3, 1, 3, 8, 0, 0);
      run(1, 0, 3, 8, 0, 0);
      run(2, 1, 4, 10, 0, 0);
      run(45, 1, 4, 5, 0, 0);
      run(2, 0, 4, 5, 0, 0);

      for (int s = 0; s < 40; s++) begin
         pre = $urandom_range(0, 20);
         if ($urandom_range(0, 3) == 0) dl = $urandom_range(0, 15);
         else dl = $urandom_range(5, 9);
         par = 1'($urandom_range(0, 1));
         st2 = 1'($urandom_range(0, 1));
         n = $urandom_range(1, 250);
         for (int i = 0; i < n; i++) begin
            e = ($urandom_range(0, 99) < 97);
            if ($urandom_range(0, 99) == 0) pre = $urandom_range(0, 20);
            step(e, pre, dl, par, st2);
         end
      end

      run(2, 0, 8, 8, 0, 0);
      run(51, 1, 8, 8, 0, 0);
      @(negedge CLK);
      #1 RST = 1'b1;
      #1 check_zero("async_reset_mid_run");
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         #1 check_zero("reset_held");
      end
      RST = 1'b0;
      m_run = 1'b0; m_k = 0; m_err = 1'b0;
      run(30, 1, 8, 8, 0, 0);
      run(2, 0, 8, 8, 0, 0);

      @(negedge CLK);
      #1 check_int("scoreboard_drained", sbq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/uart_rx_frame_counter.md
UART_RX_FRAME_COUNTER -- requirements
Module: uart_rx_frame_counter

Interface
REQ-001 SHALL have parameter PRESCALE_W, default 6, width of Prescale/edge_cnt (legal 4..8).
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port enable  input  1  frame reception active.
REQ-005 SHALL have port Prescale  input  PRESCALE_W  CLK cycles per bit (legal >= 4).
REQ-006 SHALL have port DATA_LEN  input  4  data bits per frame (legal 5..9).
REQ-007 SHALL have port PAR_EN  input  1  parity bit present.
REQ-008 SHALL have port STOP2  input  1  two stop bits when 1, else one.
REQ-009 SHALL have port edge_cnt  output  PRESCALE_W  cycle index within current bit.
REQ-010 SHALL have port bit_cnt  output  4  bit index within frame (0 = start bit).
REQ-011 SHALL have port sample_stb  output  1  oversample strobe; sample_idx  output  2  strobe index 0/1/2.
REQ-012 SHALL have port bit_done  output  1; frame_done  output  1; busy  output  1; cfg_err  output  1.

Function
REQ-013 SHALL implement states IDLE and RUN; busy = (state == RUN).
REQ-014 IDLE with enable=1 and legal config SHALL latch Prescale into P_q and FRAME_BITS_q = 2 + DATA_LEN + PAR_EN + STOP2 (range 7..13), go to RUN, set edge_cnt to 1; that cycle is edge 0 of bit 0.
REQ-015 IDLE with enable=1 and illegal config (Prescale < 4 or DATA_LEN outside 5..9) SHALL set cfg_err=1, stay IDLE, hold edge_cnt and bit_cnt at 0.
REQ-016 cfg_err SHALL clear on the cycle after enable=0 or after a legal latch.
REQ-017 RUN with enable=1 and edge_cnt < P_q-1 SHALL increment edge_cnt.
REQ-018 RUN with enable=1 and edge_cnt == P_q-1 SHALL wrap edge_cnt to 0 and increment bit_cnt, unless bit_cnt == FRAME_BITS_q-1.
REQ-019 At the final edge of bit FRAME_BITS_q-1, SHALL clear edge_cnt and bit_cnt, return to IDLE; if enable is still 1 the next cycle relatches config (REQ-014), giving back-to-back frames with no gap cycle.
REQ-020 Prescale, DATA_LEN, PAR_EN and STOP2 changes during RUN SHALL be ignored until the next latch.
REQ-021 RUN with enable=0 SHALL abort: next cycle state IDLE, edge_cnt=0, bit_cnt=0, no frame_done.
REQ-022 With M = P_q >> 1 (floor), sample_stb SHALL be 1 in RUN with enable=1 when edge_cnt is M-1, M or M+1, with sample_idx 0, 1, 2 respectively; otherwise sample_stb=0 and sample_idx=0.
REQ-023 bit_done SHALL be 1 in RUN with enable=1 and edge_cnt == P_q-1.
REQ-024 frame_done SHALL be 1 exactly when bit_done=1 and bit_cnt == FRAME_BITS_q-1.
REQ-025 sample_stb, sample_idx, bit_done and frame_done SHALL be combinational decodes of registered state and enable; they SHALL never assert in IDLE.
REQ-026 Comparisons SHALL be unsigned at PRESCALE_W bits; edge_cnt SHALL never exceed P_q-1 and bit_cnt SHALL never exceed 12.

Reset
REQ-027 RST=1 SHALL force, asynchronously, state IDLE, edge_cnt=0, bit_cnt=0, P_q=0, FRAME_BITS_q=0, cfg_err=0, busy=0; all strobes 0.
REQ-028 After RST falls, the first rising edge with enable=1 SHALL follow REQ-014/REQ-015.

Verification
REQ-029 Prescale=8, DATA_LEN=8, PAR_EN=0, STOP2=0, enable held -> 10 bits; sample_stb at edge_cnt 3,4,5 of each bit; frame_done on 80th enabled cycle; next frame starts immediately.
REQ-030 Prescale=16, DATA_LEN=9, PAR_EN=1, STOP2=1 -> bit_cnt reaches 12; frame_done on cycle 208; samples at edges 7,8,9.
REQ-031 Prescale changed 8->16 at bit 4 -> current frame keeps 8 cycles/bit; following frame uses 16.
REQ-032 enable dropped at bit 3, edge 5 -> next cycle edge_cnt=0, bit_cnt=0, busy=0; no frame_done.
REQ-033 Prescale=3 -> cfg_err=1, busy=0, no strobes; Prescale=4 -> latch, cfg_err=0 next cycle, samples at edges 1,2,3, bit_done at edge 3.
REQ-034 RST asserted mid-RUN (bit 6, edge 2) -> all outputs 0 before next CLK edge; remain 0 while RST=1.
